exu_stage: RTL and testbench
============================

// Module: exu_stage
// PURPOSE
// - Execute stage between the ID/EX register (X-side signals) and the MEM stage.
// - Computes the ALU result and the branch/jump decision and redirect target for one instruction per handshake.
// - Buffers results in a 2-entry skid FIFO, so s_ready never depends combinationally on m_ready.
// - Emits a registered one-cycle redirect pulse to fetch.
// PARAMETERS
// - XLEN        32  datapath width
// - BUF_DEPTH   2   skid entries; fixed at 2, other values unsupported
// PORTS
// - clk          in   1     clock, all state on posedge
// - rst_n        in   1     synchronous reset, active-low
// - s_valid      in   1     X-side payload valid
// - s_ready      out  1     stage can accept
// - m_valid      out  1     M-side head entry valid
// - m_ready      in   1     MEM stage accepts head
// - ALU_opX      in   3     000 ADD, 001 SUB, 010 XOR, 011 OR, 100 AND, 101 SLL, 110 SRL, 111 SRA
// - ALUsrc1X     in   2     opA: 0 src1X, 1 pcX, 2/3 zero
// - ALUsrc2X     in   2     opB: 0 src2X, 1 immX, 2/3 const 4
// - cmp_typeX    in   3     000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; others false
// - branchX, jumpX, jalrX, ecallX, mretX  in 1 each  control flags
// - src1X, src2X, immX, pcX, snpcX, csrX  in 32 each  operands
// - mvalidX, mwenX, mwmaskX[8], mrtypeX[3], csraddrX[12], rdX[5], rdregsrcX[3]  in  pass-through
// - aluresM      out  32    rdregsrcX==4: {31'b0,cmp}; else ALU result
// - src2M, snpcM, csrM, pcM  out 32  pass-through copies
// - mvalidM, mwenM, mwmaskM, mrtypeM, csraddrM, rdM, rdregsrcM, ecallM, mretM  out  pass-through copies
// - redirect     out  1     fetch redirect pulse
// - redirect_pc  out  32    redirect target
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): count=0; all M outputs 0; redirect=0; redirect_pc=32'h80000000.
// - Reset mid-operation discards all buffered entries.
// - Buffered entries are never delivered after reset.
// - s_ready = (count != 2); m_valid = (count != 0). Both are decoded from registered count only.
// - push = s_valid & s_ready; pop = m_valid & m_ready.
// - push & pop on the same cycle: count unchanged, FIFO order kept.
// - count==2: no push. count==0: no pop.
// - Latency: payload pushed at edge N into an empty buffer appears on M outputs from cycle N+1.
// - M outputs are always the head entry; they hold stable while m_valid & ~m_ready.
// - ALU: ADD/SUB wrap mod 2^32. Shift amount = opB[4:0]. SRA sign-fills from opA[31].
// - cmp is evaluated on src1X vs src2X, signed for LT/GE and unsigned for LTU/GEU.
// - taken = jumpX | (branchX & cmp).
// - target = jalrX ? ((src1X+immX) & ~32'h1) : (pcX+immX).
// - redirect: on push with taken=1, redirect=1 and redirect_pc=target in cycle N+1 for exactly one cycle.
// - Otherwise redirect=0; redirect_pc holds its last value.
// - The redirect pulse is independent of m_ready and of the buffer draining.
// - ecall/mret are passed through only; they do not generate a redirect here.
// TESTING
// - ADD: ALU_op=000, src1=7, src2=5, ALUsrc=0/0 -> aluresM=12 one cycle after push; redirect stays 0.
// - SRA/SUB: opA=32'h80000000, opB=4, SRA -> 32'hF8000000; SUB 0-1 -> 32'hFFFFFFFF.
// - Branch: BLT src1=-1, src2=1, pc=32'h80000010, imm=-16 -> redirect=1 one cycle, redirect_pc=32'h80000000.
// - Branch not taken: BLTU with the same operands -> redirect=0.
// - JALR: src1=32'h80000103, imm=4 -> redirect_pc=32'h80000106; aluresM=snpc path via rdregsrc unaffected.
// - Backpressure: m_ready=0, stream 3 pushes -> 2 accepted, s_ready=0 at count=2.
// - Backpressure release: then m_ready=1 -> entries exit in order; push+pop at count=1 keeps count=1.
// - Reset: rst_n=0 with count=2 -> next cycle m_valid=0, s_ready=1, redirect=0, all M outputs 0.

Source files
------------

// File: rtl/exu_stage.sv
// Execute stage: ALU, branch/jump resolution and redirect pulse, feeding MEM
// through a 2-entry skid buffer so s_ready is decoded from registered state only.
module exu_stage #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            m_valid,
  input  logic            m_ready,
  input  logic [2:0]      ALU_opX,
  input  logic [1:0]      ALUsrc1X,
  input  logic [1:0]      ALUsrc2X,
  input  logic [2:0]      cmp_typeX,
  input  logic            branchX,
  input  logic            jumpX,
  input  logic            jalrX,
  input  logic            ecallX,
  input  logic            mretX,
  input  logic [XLEN-1:0] src1X,
  input  logic [XLEN-1:0] src2X,
  input  logic [XLEN-1:0] immX,
  input  logic [XLEN-1:0] pcX,
  input  logic [XLEN-1:0] snpcX,
  input  logic [XLEN-1:0] csrX,
  input  logic            mvalidX,
  input  logic            mwenX,
  input  logic [7:0]      mwmaskX,
  input  logic [2:0]      mrtypeX,
  input  logic [11:0]     csraddrX,
  input  logic [4:0]      rdX,
  input  logic [2:0]      rdregsrcX,
  output logic [XLEN-1:0] aluresM,
  output logic [XLEN-1:0] src2M,
  output logic [XLEN-1:0] snpcM,
  output logic [XLEN-1:0] csrM,
  output logic [XLEN-1:0] pcM,
  output logic            mvalidM,
  output logic            mwenM,
  output logic [7:0]      mwmaskM,
  output logic [2:0]      mrtypeM,
  output logic [11:0]     csraddrM,
  output logic [4:0]      rdM,
  output logic [2:0]      rdregsrcM,
  output logic            ecallM,
  output logic            mretM,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  // Handshake: a beat transfers on a side when valid & ready are both high at
  // posedge; valid never waits on ready, and ready depends only on registers.

  typedef struct packed {
    logic [XLEN-1:0] alures;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] snpc;
    logic [XLEN-1:0] csr;
    logic [XLEN-1:0] pc;
    logic            mvalid;
    logic            mwen;
    logic [7:0]      mwmask;
    logic [2:0]      mrtype;
    logic [11:0]     csraddr;
    logic [4:0]      rd;
    logic [2:0]      rdregsrc;
    logic            ecall;
    logic            mret;
  } payload_t;

  localparam logic [1:0] FULL = BUF_DEPTH[1:0];
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  logic [XLEN-1:0] op_a, op_b, alu_res, target;
  logic            cmp, taken;
  payload_t        in_pl, head;
  payload_t        buf_q [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic            push, pop;

  always_comb begin
    op_a = '0;
    unique case (ALUsrc1X)
      2'd0:    op_a = src1X;
      2'd1:    op_a = pcX;
      default: op_a = '0;
    endcase
    op_b = '0;
    unique case (ALUsrc2X)
      2'd0:    op_b = src2X;
      2'd1:    op_b = immX;
      default: op_b = 32'd4;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (ALU_opX)
      3'b000: alu_res = op_a + op_b;
      3'b001: alu_res = op_a - op_b;
      3'b010: alu_res = op_a ^ op_b;
      3'b011: alu_res = op_a | op_b;
      3'b100: alu_res = op_a & op_b;
      3'b101: alu_res = op_a << op_b[4:0];
      3'b110: alu_res = op_a >> op_b[4:0];
      3'b111: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      default: alu_res = '0;
    endcase
  end

  // Comparison always looks at the register operands, never the muxed ALU inputs.
  always_comb begin
    cmp = 1'b0;
    case (cmp_typeX)
      3'b000:  cmp = (src1X == src2X);
      3'b001:  cmp = (src1X != src2X);
      3'b100:  cmp = ($signed(src1X) <  $signed(src2X));
      3'b101:  cmp = ($signed(src1X) >= $signed(src2X));
      3'b110:  cmp = (src1X <  src2X);
      3'b111:  cmp = (src1X >= src2X);
      default: cmp = 1'b0;
    endcase
  end

  assign taken  = jumpX | (branchX & cmp);
  assign target = jalrX ? ((src1X + immX) & ~32'h1) : (pcX + immX);

  always_comb begin
    in_pl          = '0;
    in_pl.alures   = (rdregsrcX == 3'd4) ? {{(XLEN-1){1'b0}}, cmp} : alu_res;
    in_pl.src2     = src2X;
    in_pl.snpc     = snpcX;
    in_pl.csr      = csrX;
    in_pl.pc       = pcX;
    in_pl.mvalid   = mvalidX;
    in_pl.mwen     = mwenX;
    in_pl.mwmask   = mwmaskX;
    in_pl.mrtype   = mrtypeX;
    in_pl.csraddr  = csraddrX;
    in_pl.rd       = rdX;
    in_pl.rdregsrc = rdregsrcX;
    in_pl.ecall    = ecallX;
    in_pl.mret     = mretX;
  end

  assign s_ready = (count != FULL);
  assign m_valid = (count != 2'd0);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= in_pl;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Redirect is a single-cycle pulse tied to acceptance, not to MEM draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= RESET_PC;
    end else if (push && taken) begin
      redirect    <= 1'b1;
      redirect_pc <= target;
    end else begin
      redirect    <= 1'b0;
    end
  end

  assign head      = buf_q[rd_ptr];
  assign aluresM   = head.alures;
  assign src2M     = head.src2;
  assign snpcM     = head.snpc;
  assign csrM      = head.csr;
  assign pcM       = head.pc;
  assign mvalidM   = head.mvalid;
  assign mwenM     = head.mwen;
  assign mwmaskM   = head.mwmask;
  assign mrtypeM   = head.mrtype;
  assign csraddrM  = head.csraddr;
  assign rdM       = head.rd;
  assign rdregsrcM = head.rdregsrc;
  assign ecallM    = head.ecall;
  assign mretM     = head.mret;

endmodule

// File: tb/tb_exu_stage.sv
// Bench for exu_stage: directed scenarios plus random traffic, scored against
// a queue-based reference of the stage's documented behaviour.
module tb_exu_stage;

  localparam int PW = 195;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [2:0]  ALU_opX, cmp_typeX, mrtypeX, rdregsrcX;
  logic [1:0]  ALUsrc1X, ALUsrc2X;
  logic        branchX, jumpX, jalrX, ecallX, mretX, mvalidX, mwenX;
  logic [31:0] src1X, src2X, immX, pcX, snpcX, csrX;
  logic [7:0]  mwmaskX;
  logic [11:0] csraddrX;
  logic [4:0]  rdX;
  logic [31:0] aluresM, src2M, snpcM, csrM, pcM, redirect_pc;
  logic        mvalidM, mwenM, ecallM, mretM, redirect;
  logic [7:0]  mwmaskM;
  logic [2:0]  mrtypeM, rdregsrcM;
  logic [11:0] csraddrM;
  logic [4:0]  rdM;

  logic [PW-1:0] exp_q[$];
  logic          exp_redirect;
  logic [31:0]   exp_redirect_pc;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  exu_stage dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .ALU_opX(ALU_opX),
    .ALUsrc1X(ALUsrc1X), .ALUsrc2X(ALUsrc2X), .cmp_typeX(cmp_typeX),
    .branchX(branchX), .jumpX(jumpX), .jalrX(jalrX), .ecallX(ecallX),
    .mretX(mretX), .src1X(src1X), .src2X(src2X), .immX(immX), .pcX(pcX),
    .snpcX(snpcX), .csrX(csrX), .mvalidX(mvalidX), .mwenX(mwenX),
    .mwmaskX(mwmaskX), .mrtypeX(mrtypeX), .csraddrX(csraddrX), .rdX(rdX),
    .rdregsrcX(rdregsrcX), .aluresM(aluresM), .src2M(src2M), .snpcM(snpcM),
    .csrM(csrM), .pcM(pcM), .mvalidM(mvalidM), .mwenM(mwenM),
    .mwmaskM(mwmaskM), .mrtypeM(mrtypeM), .csraddrM(csraddrM), .rdM(rdM),
    .rdregsrcM(rdregsrcM), .ecallM(ecallM), .mretM(mretM),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // ---------------- reference model ----------------
  function automatic logic ref_cmp(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (t)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return !(sa < sb);
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint      wide;
    sh = b % 32;
    case (op)
      3'b000: return a + b;
      3'b001: return a + (~b) + 32'd1;
      3'b010: return a ^ b;
      3'b011: return a | b;
      3'b100: return a & b;
      3'b101: return 32'((64'(a) * (64'd1 << sh)));
      3'b110: return a / (32'd1 << sh);
      default: begin
        wide = longint'(signed'(a));
        return 32'(wide >>> sh);
      end
    endcase
  endfunction

  function automatic logic [PW-1:0] ref_payload();
    logic [31:0] a, b, res;
    a   = (ALUsrc1X == 2'd0) ? src1X : (ALUsrc1X == 2'd1) ? pcX : 32'd0;
    b   = (ALUsrc2X == 2'd0) ? src2X : (ALUsrc2X == 2'd1) ? immX : 32'd4;
    res = (rdregsrcX == 3'd4) ? 32'(ref_cmp(cmp_typeX, src1X, src2X)) : ref_alu(ALU_opX, a, b);
    return {res, src2X, snpcX, csrX, pcX, mvalidX, mwenX, mwmaskX, mrtypeX,
            csraddrX, rdX, rdregsrcX, ecallX, mretX};
  endfunction

  function automatic logic [PW-1:0] dut_head();
    return {aluresM, src2M, snpcM, csrM, pcM, mvalidM, mwenM, mwmaskM, mrtypeM,
            csraddrM, rdM, rdregsrcM, ecallM, mretM};
  endfunction

  // Scoreboard cycle: compare outputs at negedge, then advance model at posedge.
  task automatic step();
    logic          push, pop, tk;
    logic [31:0]   tg;
    logic [PW-1:0] pl;
    n_checks++;
    if (s_ready !== (exp_q.size() != 2)) begin
      n_fail++; $display("FAIL s_ready got %b exp %b", s_ready, exp_q.size() != 2);
    end
    n_checks++;
    if (m_valid !== (exp_q.size() != 0)) begin
      n_fail++; $display("FAIL m_valid got %b exp %b", m_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      if (dut_head() !== exp_q[0]) begin
        n_fail++; $display("FAIL head got %h exp %h", dut_head(), exp_q[0]);
      end
    end
    n_checks++;
    if (redirect !== exp_redirect) begin
      n_fail++; $display("FAIL redirect got %b exp %b", redirect, exp_redirect);
    end
    n_checks++;
    if (redirect_pc !== exp_redirect_pc) begin
      n_fail++; $display("FAIL redirect_pc got %h exp %h", redirect_pc, exp_redirect_pc);
    end
    push = s_valid && (exp_q.size() < 2);
    pop  = m_ready && (exp_q.size() > 0);
    pl   = ref_payload();
    tk   = jumpX || (branchX && ref_cmp(cmp_typeX, src1X, src2X));
    tg   = jalrX ? ((src1X + immX) & 32'hFFFF_FFFE) : (pcX + immX);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      exp_redirect    = 1'b0;
      exp_redirect_pc = 32'h8000_0000;
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(pl);
      exp_redirect = push && tk;
      if (push && tk) exp_redirect_pc = tg;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    s_valid = 0; m_ready = 1; ALU_opX = 0; ALUsrc1X = 0; ALUsrc2X = 0; cmp_typeX = 0;
    branchX = 0; jumpX = 0; jalrX = 0; ecallX = 0; mretX = 0;
    src1X = 0; src2X = 0; immX = 0; pcX = 0; snpcX = 0; csrX = 0;
    mvalidX = 0; mwenX = 0; mwmaskX = 0; mrtypeX = 0; csraddrX = 0; rdX = 0; rdregsrcX = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    n_checks++;
    if (dut_head() !== '0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_state head %h m_valid %b s_ready %b exp 0/0/1", dut_head(), m_valid, s_ready);
    end
    n_checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h8000_0000) begin
      n_fail++; $display("FAIL reset_redirect got %b/%h exp 0/80000000", redirect, redirect_pc);
    end
    step();
  endtask

  task automatic test_add();
    clear_inputs();
    s_valid = 1; ALU_opX = 3'b000; src1X = 7; src2X = 5; rdX = 5'd3; snpcX = 32'h44;
    step();
    s_valid = 0;
    n_checks++;
    if (m_valid !== 1'b1 || aluresM !== 32'd12 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL add got v=%b res=%h redir=%b exp 1/0000000c/0", m_valid, aluresM, redirect);
    end
    step(); step();
  endtask

  task automatic test_sra_sub();
    clear_inputs();
    s_valid = 1; ALU_opX = 3'b111; ALUsrc2X = 2'd1; src1X = 32'h8000_0000; immX = 4;
    step();
    n_checks++;
    if (aluresM !== 32'hF800_0000) begin
      n_fail++; $display("FAIL sra got %h exp f8000000", aluresM);
    end
    ALU_opX = 3'b001; ALUsrc1X = 2'd2; immX = 1;
    step();
    s_valid = 0;
    n_checks++;
    if (aluresM !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sub got %h exp ffffffff", aluresM);
    end
    step();
  endtask

  task automatic test_jalr();
    clear_inputs();
    s_valid = 1; jumpX = 1; jalrX = 1; src1X = 32'h8000_0103; immX = 4;
    pcX = 32'h8000_0200; snpcX = 32'h8000_0204; ALUsrc1X = 2'd1; ALUsrc2X = 2'd2; rdregsrcX = 3'd1;
    step();
    s_valid = 0;
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h8000_0106 || aluresM !== 32'h8000_0204) begin
      n_fail++; $display("FAIL jalr got %b/%h res %h exp 1/80000106 res 80000204", redirect, redirect_pc, aluresM);
    end
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    s_valid = 1; branchX = 1; cmp_typeX = 3'b100; src1X = 32'hFFFF_FFFF; src2X = 1;
    pcX = 32'h8000_0010; immX = 32'hFFFF_FFF0;
    step();
    n_checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h8000_0000) begin
      n_fail++; $display("FAIL blt got %b/%h exp 1/80000000", redirect, redirect_pc);
    end
    cmp_typeX = 3'b110;
    step();
    s_valid = 0;
    n_checks++;
    if (redirect !== 1'b0) begin
      n_fail++; $display("FAIL bltu got %b exp 0", redirect);
    end
    step();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    m_ready = 0; s_valid = 1;
    for (int i = 0; i < 3; i++) begin
      src1X = 32'h100 + i; src2X = 32'h10 * i; rdX = 5'(i + 1);
      step();
    end
    n_checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || aluresM !== 32'h100) begin
      n_fail++; $display("FAIL bp_full got rdy %b v %b res %h exp 0/1/00000100", s_ready, m_valid, aluresM);
    end
    s_valid = 0; m_ready = 1;
    step();
    n_checks++;
    if (aluresM !== 32'h111) begin
      n_fail++; $display("FAIL bp_order got %h exp 00000111", aluresM);
    end
    step();
    m_ready = 0; s_valid = 1; src1X = 32'h500; src2X = 0;
    step();
    m_ready = 1; src1X = 32'h600;
    step();
    s_valid = 0;
    n_checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b1 || aluresM !== 32'h600) begin
      n_fail++; $display("FAIL push_pop got v %b rdy %b res %h exp 1/1/00000600", m_valid, s_ready, aluresM);
    end
    step(); step();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    m_ready = 0; s_valid = 1; src1X = 1; src2X = 2; mwmaskX = 8'hFF; rdX = 5'd9;
    step();
    jumpX = 1; immX = 32'h40; pcX = 32'h8000_1000;
    step();
    rst_n = 0; s_valid = 0;
    step();
    rst_n = 1;
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || redirect !== 1'b0 || dut_head() !== '0) begin
      n_fail++; $display("FAIL reset_mid got v %b rdy %b redir %b head %h exp 0/1/0/0", m_valid, s_ready, redirect, dut_head());
    end
    m_ready = 1;
    step(); step();
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 600; i++) begin
      s_valid   = ($urandom_range(0, 99) < 65);
      m_ready   = ($urandom_range(0, 99) < 60);
      ALU_opX   = 3'($urandom_range(0, 7));
      ALUsrc1X  = 2'($urandom_range(0, 3));
      ALUsrc2X  = 2'($urandom_range(0, 3));
      cmp_typeX = 3'($urandom_range(0, 7));
      branchX   = $urandom_range(0, 1);
      jumpX     = ($urandom_range(0, 7) == 0);
      jalrX     = $urandom_range(0, 1);
      ecallX    = $urandom_range(0, 1);
      mretX     = $urandom_range(0, 1);
      src1X     = ($urandom_range(0, 3) == 0) ? src2X : $urandom;
      src2X     = $urandom;
      immX      = $urandom; pcX = $urandom; snpcX = $urandom; csrX = $urandom;
      mvalidX   = $urandom_range(0, 1); mwenX = $urandom_range(0, 1);
      mwmaskX   = 8'($urandom); mrtypeX = 3'($urandom); csraddrX = 12'($urandom);
      rdX       = 5'($urandom); rdregsrcX = 3'($urandom_range(0, 7));
      step();
    end
    clear_inputs();
    step(); step(); step();
  endtask

  initial begin
    exp_redirect    = 1'b0;
    exp_redirect_pc = 32'h8000_0000;
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_add();
    test_sra_sub();
    test_jalr();
    test_branch();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
